fluxo_dados_genius_n: RTL and testbench

Parametrised data path for the memory-game circuit, driven by the existing game control unit. It generalises the 4-button/16-position data path to N buttons and 2^ADDR_W sequence positions. The ROM is replaced by a synchronous writable RAM, so the player can append new plays (write mode). It adds play-validity checking (exactly one button pressed) and a sticky, parametrised timeout.

---
 rtl/fluxo_dados_genius_n_pkg.sv | 10 +
 rtl/contador_m.sv | 17 +
 rtl/ram_sync_n.sv | 17 +
 rtl/fluxo_dados_genius_n.sv | 74 +++++++
 tb/tb_fluxo_dados_genius_n.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/fluxo_dados_genius_n_pkg.sv
// fluxo_dados_genius_n_pkg: default sizes for the memory-game data path and a counter-width helper
package fluxo_dados_genius_n_pkg;
  localparam int DEF_N_BOTOES  = 4;
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_TIMEOUT_M = 5000;
  localparam int DEF_TMR_M     = 500;
  function automatic int cw(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/contador_m.sv
// contador_m: modulo-M up counter with sync reset, sync clear and count enable
module contador_m
  import fluxo_dados_genius_n_pkg::*;
#(
  parameter int M = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               zera,
  input  logic               conta,
  output logic [cw(M)-1:0]   q
);
  localparam int W = cw(M);
  always_ff @(posedge clock)
    if (reset || zera) q <= '0;
    else if (conta) q <= (q == W'(M - 1)) ? '0 : q + 1'b1;
endmodule

// File: rtl/ram_sync_n.sv
// ram_sync_n: zero-initialised RAM with synchronous write and registered (1-cycle) read
module ram_sync_n #(
  parameter int W = 4,
  parameter int A = 4
) (
  input  logic         clock,
  input  logic         we,
  input  logic [A-1:0] addr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] r_mem [2**A] = '{default: '0};
  always_ff @(posedge clock) begin
    if (we) r_mem[addr] <= din;
    dout <= r_mem[addr];
  end
endmodule

// File: rtl/fluxo_dados_genius_n.sv
// fluxo_dados_genius_n: parametrised memory-game data path with writable sequence RAM and idle timeout
module fluxo_dados_genius_n
  import fluxo_dados_genius_n_pkg::*;
#(
  parameter int N_BOTOES  = DEF_N_BOTOES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int TIMEOUT_M = DEF_TIMEOUT_M,
  parameter int TMR_M     = DEF_TMR_M
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                zeraE,
  input  logic                zeraS,
  input  logic                zeraR,
  input  logic                zeraTMR,
  input  logic                contaE,
  input  logic                contaS,
  input  logic                contaTMR,
  input  logic                registraR,
  input  logic                escreveM,
  output logic                fimE,
  output logic                fimS,
  output logic                fimTMR,
  output logic                jogada_feita,
  output logic                jogada_valida,
  output logic                chavesIgualMemoria,
  output logic                enderecoIgualSequencia,
  output logic                enderecoMenorQueSequencia,
  output logic                timeout,
  output logic                db_tem_jogada,
  output logic [ADDR_W-1:0]   db_contagem,
  output logic [ADDR_W-1:0]   db_sequencia,
  output logic [N_BOTOES-1:0] db_jogada,
  output logic [N_BOTOES-1:0] db_memoria
);
  localparam int TMR_W = cw(TMR_M);
  localparam int TO_W  = cw(TIMEOUT_M);
  logic                w_tem;
  logic [TMR_W-1:0]    w_tmr_q;
  logic [TO_W-1:0]     w_to_q;
  logic                w_to_clr, w_to_en;
  logic [N_BOTOES-1:0] r_jogada;
  logic                r_prev, r_timeout;
  assign w_tem = |botoes;
  contador_m #(.M(2**ADDR_W)) u_cont_e (.clock, .reset, .zera(zeraE), .conta(contaE), .q(db_contagem));
  contador_m #(.M(2**ADDR_W)) u_cont_s (.clock, .reset, .zera(zeraS), .conta(contaS), .q(db_sequencia));
  contador_m #(.M(TMR_M)) u_tmr (.clock, .reset, .zera(zeraTMR), .conta(contaTMR), .q(w_tmr_q));
  // idle counter restarts whenever the control unit advances the address
  assign w_to_clr = zeraE | contaE;
  assign w_to_en  = ~w_tem & ~r_timeout;
  contador_m #(.M(TIMEOUT_M)) u_to (.clock, .reset, .zera(w_to_clr), .conta(w_to_en), .q(w_to_q));
  ram_sync_n #(.W(N_BOTOES), .A(ADDR_W)) u_ram (
    .clock, .we(escreveM), .addr(db_contagem), .din(r_jogada), .dout(db_memoria)
  );
  always_ff @(posedge clock) begin
    if (reset || zeraR) r_jogada <= '0;
    else if (registraR) r_jogada <= botoes;
    r_prev <= reset ? 1'b0 : w_tem;
    if (reset || w_to_clr) r_timeout <= 1'b0;
    else if (w_to_en && w_to_q == TO_W'(TIMEOUT_M - 1)) r_timeout <= 1'b1;
  end
  assign fimE                      = &db_contagem;
  assign fimS                      = &db_sequencia;
  assign fimTMR                    = w_tmr_q == TMR_W'(TMR_M - 1);
  assign jogada_feita              = w_tem & ~r_prev;
  assign jogada_valida             = $countones(r_jogada) == 1;
  assign chavesIgualMemoria        = r_jogada == db_memoria;
  assign enderecoIgualSequencia    = db_contagem == db_sequencia;
  assign enderecoMenorQueSequencia = db_contagem < db_sequencia;
  assign timeout                   = r_timeout;
  assign db_tem_jogada             = w_tem;
  assign db_jogada                 = r_jogada;
endmodule

// File: tb/tb_fluxo_dados_genius_n.sv
// tb_fluxo_dados_genius_n: directed scoreboard bench for the parametrised memory-game data path
module tb_fluxo_dados_genius_n;
  logic clock = 0, reset = 1;
  logic [3:0] botoes = '0;
  logic zeraE = 0, zeraS = 0, zeraR = 0, zeraTMR = 0, contaE = 0, contaS = 0, contaTMR = 0;
  logic registraR = 0, escreveM = 0;
  logic fimE, fimS, fimTMR, jogada_feita, jogada_valida, chavesIgualMemoria;
  logic enderecoIgualSequencia, enderecoMenorQueSequencia, timeout, db_tem_jogada;
  logic [2:0] db_contagem, db_sequencia;
  logic [3:0] db_jogada, db_memoria;
  int total = 0, bad = 0;
  typedef struct { string tag; logic [31:0] v; } exp_t;
  exp_t sb[$];

  fluxo_dados_genius_n #(.N_BOTOES(4), .ADDR_W(3), .TIMEOUT_M(8), .TMR_M(5)) dut (
    .clock(clock), .reset(reset), .botoes(botoes),
    .zeraE(zeraE), .zeraS(zeraS), .zeraR(zeraR), .zeraTMR(zeraTMR),
    .contaE(contaE), .contaS(contaS), .contaTMR(contaTMR),
    .registraR(registraR), .escreveM(escreveM),
    .fimE(fimE), .fimS(fimS), .fimTMR(fimTMR),
    .jogada_feita(jogada_feita), .jogada_valida(jogada_valida),
    .chavesIgualMemoria(chavesIgualMemoria),
    .enderecoIgualSequencia(enderecoIgualSequencia),
    .enderecoMenorQueSequencia(enderecoMenorQueSequencia),
    .timeout(timeout), .db_tem_jogada(db_tem_jogada),
    .db_contagem(db_contagem), .db_sequencia(db_sequencia),
    .db_jogada(db_jogada), .db_memoria(db_memoria)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty got=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s got=%0h want=%0h", e.tag, obs, e.v);
      end
    end
  endtask

  initial begin
    int n;
    tick(2);
    reset = 0;
    push("rst_cont", 0);  chk(32'(db_contagem));
    push("rst_seq", 0);   chk(32'(db_sequencia));
    push("rst_jog", 0);   chk(32'(db_jogada));
    push("rst_mem", 0);   chk(32'(db_memoria));
    push("rst_to", 0);    chk(32'(timeout));
    push("rst_feita", 0); chk(32'(jogada_feita));
    push("rst_valida", 0); chk(32'(jogada_valida));
    push("rst_fimE", 0);  chk(32'(fimE));

    botoes = 4'b0100; registraR = 1;
    push("reg_jog", 4'b0100); push("reg_valida", 1);
    tick();
    registraR = 0; botoes = 0;
    chk(32'(db_jogada)); chk(32'(jogada_valida));
    contaE = 1; push("addr3", 3); tick(3); contaE = 0; chk(32'(db_contagem));
    escreveM = 1; push("wr_old", 0); tick(); escreveM = 0; chk(32'(db_memoria));
    contaE = 1; tick(); contaE = 0;
    zeraE = 1; push("zeraE", 0); tick(); zeraE = 0; chk(32'(db_contagem));
    contaE = 1; tick(3); contaE = 0;
    push("rd_lat", 0); chk(32'(db_memoria));
    push("rd_lat_cmp", 0); chk(32'(chavesIgualMemoria));
    tick();
    push("rd_back", 4'b0100); chk(32'(db_memoria));
    push("rd_cmp", 1); chk(32'(chavesIgualMemoria));

    zeraR = 1; tick(); zeraR = 0;
    push("val_0000", 0); chk(32'(jogada_valida));
    botoes = 4'b0110; registraR = 1; tick();
    push("val_0110", 0); chk(32'(jogada_valida));
    botoes = 4'b1000; tick(); registraR = 0;
    push("val_1000", 1); chk(32'(jogada_valida));

    botoes = 0; tick();
    botoes = 4'b0010; #1;
    n = int'(jogada_feita);
    for (int i = 0; i < 9; i++) begin tick(); n += int'(jogada_feita); end
    push("edge_hold", 1); chk(32'(n));
    botoes = 0; tick();
    botoes = 4'b0010; #1;
    push("edge_repress", 1); chk(32'(jogada_feita));
    tick();
    push("edge_after", 0); chk(32'(jogada_feita));
    botoes = 0;

    reset = 1; tick(); reset = 0;
    tick(7);
    push("to_early", 0); chk(32'(timeout));
    tick();
    push("to_rise", 1); chk(32'(timeout));
    botoes = 4'b0001; tick(); botoes = 0; tick(3);
    push("to_sticky", 1); chk(32'(timeout));
    contaE = 1; tick(); contaE = 0;
    push("to_clear", 0); chk(32'(timeout));
    tick(5);
    botoes = 4'b0001; tick(10); botoes = 0;
    tick(2);
    push("to_hold", 0); chk(32'(timeout));
    tick();
    push("to_hold_rise", 1); chk(32'(timeout));
    contaE = 1; tick(); contaE = 0;
    tick(7);
    contaE = 1; tick(); contaE = 0;
    push("to_clr_wins", 0); chk(32'(timeout));

    reset = 1; tick(); reset = 0;
    contaE = 1; tick(7); contaE = 0;
    push("wrap_fimE", 1); chk(32'(fimE));
    push("wrap_q7", 7); chk(32'(db_contagem));
    contaE = 1; tick(); contaE = 0;
    push("wrap_q0", 0); chk(32'(db_contagem));
    push("wrap_fimE0", 0); chk(32'(fimE));
    contaS = 1; tick(2); contaS = 0;
    contaE = 1; tick(); contaE = 0;
    push("a1_menor", 1); chk(32'(enderecoMenorQueSequencia));
    push("a1_igual", 0); chk(32'(enderecoIgualSequencia));
    contaE = 1; tick(); contaE = 0;
    push("a2_igual", 1); chk(32'(enderecoIgualSequencia));
    push("a2_menor", 0); chk(32'(enderecoMenorQueSequencia));
    contaS = 1; tick(5); contaS = 0;
    push("fimS", 1); chk(32'(fimS));

    zeraTMR = 1; tick(); zeraTMR = 0;
    contaTMR = 1; tick(4); contaTMR = 0;
    push("tmr_fim", 1); chk(32'(fimTMR));
    contaTMR = 1; tick(); contaTMR = 0;
    push("tmr_wrap", 0); chk(32'(fimTMR));

    contaE = 1; contaS = 1; contaTMR = 1; tick(3);
    reset = 1; tick(); reset = 0; contaE = 0; contaS = 0; contaTMR = 0;
    push("mid_rst_e", 0); chk(32'(db_contagem));
    push("mid_rst_s", 0); chk(32'(db_sequencia));
    push("mid_rst_tmr", 0); chk(32'(fimTMR));
    tick(3);
    push("mid_rst_tmr3", 0); chk(32'(fimTMR));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
